// File: rtl/lsu_pkg.sv
// Shared encodings and alignment rule for the load/store initiator.
// Pure definitions; no latency or flow-control implications.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } lsu_state_t;

    // Size 11 has no legal alignment, so it always reports as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane extract/extend for loads and lane merge for stores on a 32-bit word.
// Purely combinational; no backpressure.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sign;

    always_comb begin
        w_byte   = i_word[{i_addr, 3'b000} +: 8];
        w_half   = i_word[{i_addr[1], 4'b0000} +: 16];
        w_sign   = 1'b0;
        o_load   = i_word;
        o_merged = i_word;
        case (i_size)
            SZ_BYTE: begin
                w_sign = !i_unsigned && w_byte[7];
                o_load = {{24{w_sign}}, w_byte};
                o_merged[{i_addr, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                w_sign = !i_unsigned && w_half[15];
                o_load = {{16{w_sign}}, w_half};
                o_merged[{i_addr[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: begin
                o_load   = i_word;
                o_merged = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu_rmw.sv
// Load/store initiator onto a word-only memory; sub-word stores are read-modify-write.
// Latency 1 (error) / 2 (load, word store) / 3 (sub-word store); one request in flight, req_ready low until back in IDLE.
module mem_lsu_rmw
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic              mem_writeEn,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    input  logic [DATA_W-1:0] mem_readData
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("mem_lsu_rmw: DATA_W must be 32");
    end

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_write;
    logic              r_unsigned;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] r_rdata;
    logic              r_error;
    logic              w_accept;
    logic              w_err;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merged;

    lsu_lane_align u_align (
        .i_word     (mem_readData),
        .i_addr     (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );

    assign mem_address   = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_writeData = r_word;

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_err       = is_misaligned(req_size, req_addr[1:0]);
        req_ready   = 1'b0;
        mem_writeEn = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = '0;
        resp_error  = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    w_accept = 1'b1;
                    if (w_err)
                        w_next = RESP;
                    else if (req_write && req_size == SZ_WORD)
                        w_next = WR;
                    else
                        w_next = RD;
                end
            end
            RD: w_next = r_write ? WR : RESP;
            WR: begin
                // Gated so a reset landing on the write cycle never commits.
                mem_writeEn = !rst;
                w_next      = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = r_rdata;
                resp_error = r_error;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_size     <= SZ_BYTE;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_word     <= '0;
            r_rdata    <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr     <= req_addr;
                r_size     <= req_size;
                r_write    <= req_write;
                r_unsigned <= req_unsigned;
                r_wdata    <= req_wdata;
                r_word     <= req_wdata;
                r_rdata    <= '0;
                r_error    <= w_err;
            end
            if (r_state == RD) begin
                if (r_write)
                    r_word <= w_merged;
                else
                    r_rdata <= w_load;
            end
        end
    end

endmodule
